guess_scorer: RTL and testbench
===============================

GUESS_SCORER -- requirements
Module: guess_scorer

Interface
REQ-001 Parameters, one per line, SHALL be:
  MAX_ATTEMPTS, default 10, guesses allowed per game (only used with GUESS_SCORER_LIMIT_EN).
  COLOR_W, default 3, width of one color code (8 colors).
REQ-002 Ports, in this order, SHALL be:
  clk  in  1  single clock; all state changes on rising edge.
  rst  in  1  synchronous active-high reset.
  submit  in  1  one-cycle pulse: score current guess.
  guess0..guess3  in  COLOR_W each  player guess, positions 0-3.
  secret0..secret3  in  COLOR_W each  hidden code, positions 0-3.
  busy  out  1  evaluation in progress.
  done  out  1  one-cycle pulse: result registers updated.
  exact  out  3  positions with matching color (0-4).
  partial  out  3  right color, wrong position (0-4).
  win  out  1  last result had exact == 4.
  attempts  out  4  scored guesses this game (GUESS_SCORER_LIMIT_EN only).
  game_over  out  1  no further guesses accepted (GUESS_SCORER_LIMIT_EN only).
REQ-003 Reset SHALL be synchronous and active-high on a single clock clk; no other clock or asynchronous reset SHALL exist.

Function
REQ-004 FSM states SHALL be IDLE, EXACT, COLOR, DONE.
REQ-005 In IDLE, submit=1 SHALL latch guess0..3 and secret0..3 into internal registers, clear accumulators, and enter EXACT next cycle.
REQ-006 EXACT SHALL last 4 cycles, examining position i=0..3 in order, adding 1 to exact accumulator when latched guess_i == secret_i.
REQ-007 COLOR SHALL last 8 cycles, color c=0..7 in order, adding min(count of c in latched guess, count of c in latched secret) to a total accumulator.
REQ-008 DONE SHALL last 1 cycle: done=1, exact <= exact accumulator, partial <= total - exact accumulator, win <= (exact accumulator == 4); then return to IDLE.
REQ-009 done SHALL assert exactly 13 cycles after the edge that sampled submit; results SHALL be visible on exact/partial/win in the same cycle done=1.
REQ-010 busy SHALL be 1 in EXACT, COLOR and DONE, 0 in IDLE.
REQ-011 submit while busy=1 SHALL be ignored (not queued); input changes after latch SHALL not affect the result.
REQ-012 exact, partial, win SHALL hold their last values until the next DONE or reset; exact + partial SHALL never exceed 4.

Reset
REQ-013 rst=1 SHALL force IDLE and zero busy, done, exact, partial, win, attempts, game_over and all accumulators at the next edge.
REQ-014 rst asserted mid-evaluation SHALL abort it; no done pulse SHALL follow; submit with rst=1 SHALL be ignored.

Configuration
REQ-015 Macro GUESS_SCORER_LIMIT_EN defined: attempts and game_over ports exist; attempts increments by 1 in each DONE cycle, saturating at MAX_ATTEMPTS; game_over <= 1 in DONE when win or attempts reaches MAX_ATTEMPTS; while game_over=1, submit SHALL be ignored until rst.
REQ-016 Macro undefined: attempts and game_over ports and logic SHALL be absent; submits accepted indefinitely.

Structure
REQ-017 Shared package guess_pkg SHALL hold the FSM state enum, NUM_POS=4, NUM_COLORS=8, COLOR_W default, and the count width (3 bits).
REQ-018 One sub-module color_count SHALL return how many of four COLOR_W entries equal a given color; instantiated twice (guess, secret).

Verification
REQ-019 Bench SHALL cover:
  secret 1,2,3,4; guess 1,2,3,4 -> done at +13 cycles, exact=4, partial=0, win=1.
  secret 1,2,3,4; guess 4,3,2,1 -> exact=0, partial=4, win=0.
  secret 1,1,2,2; guess 1,2,1,5 -> exact=1, partial=2.
  secret 0,0,0,0; guess 7,7,7,7; second submit at cycle +5 -> single done, exact=0, partial=0; second submit ignored.
  rst asserted at cycle +7 of evaluation -> no done, all outputs 0, busy=0 next cycle.
  LIMIT_EN, MAX_ATTEMPTS=2, two non-winning guesses -> attempts=2, game_over=1; third submit -> busy stays 0.

Source files
------------

// File: rtl/guess_pkg.sv
// Shared types and constants for the guess scorer.
// Holds the FSM state enum, code geometry, count width and a min helper.
package guess_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXACT,
        COLOR,
        DONE
    } state_t;

    localparam int NUM_POS     = 4;
    localparam int NUM_COLORS  = 8;
    localparam int COLOR_W_DEF = 3;
    localparam int CNT_W       = 3;

    function automatic logic [CNT_W-1:0] min_cnt(
        input logic [CNT_W-1:0] a,
        input logic [CNT_W-1:0] b
    );
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/guess_scorer_color_count.sv
// color_count: number of the four entries equal to a given color.
// Ports: entries_i (four packed codes), color_i (probe), count_o (0-4).
module color_count
    import guess_pkg::*;
#(
    parameter int COLOR_W = COLOR_W_DEF
) (
    input  logic [NUM_POS-1:0][COLOR_W-1:0] entries_i,
    input  logic [COLOR_W-1:0]              color_i,
    output logic [CNT_W-1:0]                count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < NUM_POS; i++) begin
            if (entries_i[i] == color_i) begin
                count_o = count_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/guess_scorer.sv
// guess_scorer: sequential Mastermind-style scorer (4 exact + 8 color cycles).
// Ports: clk, rst (sync, high), submit pulse, guess0-3, secret0-3 in;
// busy, done pulse, exact, partial, win out. With GUESS_SCORER_LIMIT_EN
// defined, attempts and game_over are added and submits stop at game over.
module guess_scorer
    import guess_pkg::*;
#(
    parameter int MAX_ATTEMPTS = 10,
    parameter int COLOR_W      = COLOR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               submit,
    input  logic [COLOR_W-1:0] guess0,
    input  logic [COLOR_W-1:0] guess1,
    input  logic [COLOR_W-1:0] guess2,
    input  logic [COLOR_W-1:0] guess3,
    input  logic [COLOR_W-1:0] secret0,
    input  logic [COLOR_W-1:0] secret1,
    input  logic [COLOR_W-1:0] secret2,
    input  logic [COLOR_W-1:0] secret3,
    output logic               busy,
    output logic               done,
    output logic [2:0]         exact,
    output logic [2:0]         partial,
    output logic               win
`ifdef GUESS_SCORER_LIMIT_EN
    ,
    output logic [3:0]         attempts,
    output logic               game_over
`endif
);

    state_t state_q, state_d;

    logic [NUM_POS-1:0][COLOR_W-1:0] gq_q, sq_q;
    logic [2:0]       cnt_q;
    logic [CNT_W-1:0] ex_acc_q, tot_acc_q;
    logic [CNT_W-1:0] g_cnt, s_cnt;
    logic [2:0]       exact_q, partial_q;
    logic             win_q, done_q;
    logic             blocked, accept, pos_hit, win_d;

    assign accept  = (state_q == IDLE) && submit && !blocked;
    assign pos_hit = gq_q[cnt_q[1:0]] == sq_q[cnt_q[1:0]];
    assign win_d   = ex_acc_q == CNT_W'(NUM_POS);

    color_count #(.COLOR_W(COLOR_W)) u_cnt_g (
        .entries_i(gq_q),
        .color_i  (COLOR_W'(cnt_q)),
        .count_o  (g_cnt)
    );

    color_count #(.COLOR_W(COLOR_W)) u_cnt_s (
        .entries_i(sq_q),
        .color_i  (COLOR_W'(cnt_q)),
        .count_o  (s_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (accept) state_d = EXACT;
            EXACT: if (cnt_q == 3'(NUM_POS - 1)) state_d = COLOR;
            COLOR: if (cnt_q == 3'(NUM_COLORS - 1)) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gq_q      <= '0;
            sq_q      <= '0;
            cnt_q     <= '0;
            ex_acc_q  <= '0;
            tot_acc_q <= '0;
            exact_q   <= '0;
            partial_q <= '0;
            win_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        gq_q      <= {guess3, guess2, guess1, guess0};
                        sq_q      <= {secret3, secret2, secret1, secret0};
                        cnt_q     <= '0;
                        ex_acc_q  <= '0;
                        tot_acc_q <= '0;
                    end
                end
                EXACT: begin
                    if (pos_hit) ex_acc_q <= ex_acc_q + CNT_W'(1);
                    // Restart the index so COLOR begins at color 0.
                    if (cnt_q == 3'(NUM_POS - 1)) cnt_q <= '0;
                    else                          cnt_q <= cnt_q + 3'd1;
                end
                COLOR: begin
                    tot_acc_q <= tot_acc_q + min_cnt(g_cnt, s_cnt);
                    cnt_q     <= cnt_q + 3'd1;
                end
                DONE: begin
                    done_q    <= 1'b1;
                    exact_q   <= ex_acc_q;
                    partial_q <= tot_acc_q - ex_acc_q;
                    win_q     <= win_d;
                end
                default: ;
            endcase
        end
    end

    assign done    = done_q;
    assign exact   = exact_q;
    assign partial = partial_q;
    assign win     = win_q;

`ifdef GUESS_SCORER_LIMIT_EN
    localparam logic [3:0] MAX_A = 4'(MAX_ATTEMPTS);

    logic [3:0] att_q, att_nx;
    logic       go_q;

    assign att_nx = (att_q < MAX_A) ? att_q + 4'd1 : att_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            att_q <= '0;
            go_q  <= 1'b0;
        end else if (state_q == DONE) begin
            att_q <= att_nx;
            go_q  <= win_d || (att_nx == MAX_A);
        end
    end

    assign blocked   = go_q;
    assign attempts  = att_q;
    assign game_over = go_q;
`else
    localparam int unused_max_attempts = MAX_ATTEMPTS;

    assign blocked = 1'b0;
`endif

endmodule

// File: tb/tb_guess_scorer.sv
// Scoreboard bench for guess_scorer: directed games, abort and limit cases.
// Stimulus pushes expected results; a negedge monitor checks each done pulse.
module tb_guess_scorer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       submit = 1'b0;
    logic [2:0] g0 = '0, g1 = '0, g2 = '0, g3 = '0;
    logic [2:0] s0 = '0, s1 = '0, s2 = '0, s3 = '0;
    logic       busy, done, win;
    logic [2:0] exact, partial;
    logic [3:0] attempts;
    logic       game_over;

    int nchk = 0;
    int nfail = 0;
    int cyc = 0;

    typedef struct {
        int ex;
        int pa;
        int w;
        int at;
        int go;
        int cyc;
    } exp_t;

    exp_t sb[$];

`ifdef GUESS_SCORER_LIMIT_EN
    guess_scorer #(.MAX_ATTEMPTS(2), .COLOR_W(3)) dut (
`else
    assign attempts  = '0;
    assign game_over = 1'b0;
    guess_scorer #(.MAX_ATTEMPTS(10), .COLOR_W(3)) dut (
`endif
        .clk(clk), .rst(rst), .submit(submit),
        .guess0(g0), .guess1(g1), .guess2(g2), .guess3(g3),
        .secret0(s0), .secret1(s1), .secret2(s2), .secret3(s3),
        .busy(busy), .done(done), .exact(exact),
        .partial(partial), .win(win)
`ifdef GUESS_SCORER_LIMIT_EN
        , .attempts(attempts), .game_over(game_over)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        nchk++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("latency", cyc, e.cyc);
                chk("exact", int'(exact), e.ex);
                chk("partial", int'(partial), e.pa);
                chk("win", int'(win), e.w);
`ifdef GUESS_SCORER_LIMIT_EN
                chk("attempts", int'(attempts), e.at);
                chk("game_over", int'(game_over), e.go);
`endif
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_in(input int a0, a1, a2, a3,
                          input int b0, b1, b2, b3);
        g0 = 3'(a0); g1 = 3'(a1); g2 = 3'(a2); g3 = 3'(a3);
        s0 = 3'(b0); s1 = 3'(b1); s2 = 3'(b2); s3 = 3'(b3);
    endtask

    task automatic pulse();
        submit = 1'b1;
        @(posedge clk);
        #1;
        submit = 1'b0;
    endtask

    task automatic issue(input int ex, pa, w, at, go);
        exp_t e;
        pulse();
        e.ex = ex; e.pa = pa; e.w = w;
        e.at = at; e.go = go;
        e.cyc = cyc + 13;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            nchk++;
            nfail++;
            $display("FAIL done_timeout: %0d results pending", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_exact", int'(exact), 0);
        chk("rst_partial", int'(partial), 0);
        chk("rst_win", int'(win), 0);
        chk("rst_attempts", int'(attempts), 0);
        chk("rst_game_over", int'(game_over), 0);

        set_in(1, 2, 3, 4, 1, 2, 3, 4);
        issue(4, 0, 1, 1, 1);
        chk("busy_eval", int'(busy), 1);
        set_in(7, 0, 7, 0, 5, 5, 5, 5);
        wait_done();
        chk("done_pulse", int'(done), 0);
        chk("hold_exact", int'(exact), 4);
        chk("hold_win", int'(win), 1);

        do_reset();
        set_in(4, 3, 2, 1, 1, 2, 3, 4);
        issue(0, 4, 0, 1, 0);
        wait_done();

        do_reset();
        set_in(1, 2, 1, 5, 1, 1, 2, 2);
        issue(1, 2, 0, 1, 0);
        wait_done();

        do_reset();
        set_in(7, 7, 7, 7, 0, 0, 0, 0);
        issue(0, 0, 0, 1, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("busy_at_5", int'(busy), 1);
        set_in(1, 2, 3, 4, 1, 2, 3, 4);
        pulse();
        wait_done();
        repeat (16) @(posedge clk);
        #1;
        chk("ignored_busy", int'(busy), 0);
        chk("ignored_exact", int'(exact), 0);

        do_reset();
        set_in(1, 2, 1, 5, 1, 1, 2, 2);
        issue(1, 2, 0, 1, 0);
        wait_done();
        set_in(1, 2, 3, 4, 1, 2, 3, 4);
        pulse();
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        submit = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        submit = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_exact", int'(exact), 0);
        chk("abort_partial", int'(partial), 0);
        chk("abort_win", int'(win), 0);
        repeat (20) @(posedge clk);
        #1;
        chk("abort_idle", int'(busy), 0);

`ifdef GUESS_SCORER_LIMIT_EN
        do_reset();
        set_in(0, 0, 0, 0, 1, 2, 3, 4);
        issue(0, 0, 0, 1, 0);
        wait_done();
        set_in(4, 3, 2, 1, 1, 2, 3, 4);
        issue(0, 4, 0, 2, 1);
        wait_done();
        set_in(1, 2, 3, 4, 1, 2, 3, 4);
        pulse();
        for (int i = 0; i < 3; i++) begin
            chk("over_busy", int'(busy), 0);
            @(posedge clk);
            #1;
        end
        repeat (16) @(posedge clk);
        #1;
        chk("over_attempts", int'(attempts), 2);
        chk("over_win", int'(win), 0);
`endif

        if (sb.size() != 0) begin
            nchk++;
            nfail++;
            $display("FAIL leftover_results: %0d pending", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
